simon_byte_loader: RTL and testbench

Byte-serial host interface wrapped around the simon cipher core. It loads the key and the plaintext one byte at a time from the 8-bit pad bus and pulses the core to start. It then captures the ciphertext on done and streams it back out a byte at a time. All transfers use valid/ready handshakes. It replaces the replicated-byte wiring so the full key and block can be loaded from pins.

---
 rtl/simon_byte_loader_pkg.sv | 23 ++
 rtl/simon_byte_loader_watchdog.sv | 36 +++
 rtl/simon_byte_loader.sv | 161 ++++++++++++++++
 tb/tb_simon_byte_loader.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/simon_byte_loader_pkg.sv
// Shared types and helpers for the simon byte loader.
//   state_e      : loader FSM states
//   DEF_BLOCK_W  : default cipher block width (bits)
//   DEF_KEY_W    : default cipher key width (bits)
//   cnt_w()      : counter width able to hold values 0..n-1 (min 1 bit)
package simon_loader_pkg;

  typedef enum logic [2:0] {
    LOAD_KEY = 3'd0,
    LOAD_PT  = 3'd1,
    START    = 3'd2,
    BUSY     = 3'd3,
    DRAIN    = 3'd4
  } state_e;

  localparam int DEF_BLOCK_W = 32;
  localparam int DEF_KEY_W   = 64;

  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/simon_byte_loader_watchdog.sv
// Cycle counter used to bound the wait for the cipher core.
//   clk_i, rst_i : clock, synchronous active-high reset
//   clr_i        : return the count to zero
//   en_i         : advance the count by one this cycle
//   hit_o        : the count is one short of TIMEOUT_CYCLES, so an enabled
//                  cycle now completes the timeout (never set when
//                  TIMEOUT_CYCLES is 0)
module simon_loader_watchdog
  import simon_loader_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic hit_o
);

  localparam int W = cnt_w(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Ungated by en_i so the parent can gate it without a combinational loop.
  assign hit_o = (TIMEOUT_CYCLES != 0) && (cnt_q == LAST);

endmodule

// File: rtl/simon_byte_loader.sv
// Byte-serial host front end for the simon cipher core.
// Loads the key then the plaintext LSB-first from in_byte, pulses the core,
// captures the ciphertext on cipher_done and streams it out LSB-first.
//   clk, rst                    : clock, synchronous active-high reset
//   in_byte/in_valid/in_ready   : host -> loader byte stream
//   keep_key                    : sampled with the last output byte; 1 skips
//                                 the key load for the next block
//   out_byte/out_valid/out_ready: loader -> host byte stream
//   cipher_*                    : core plaintext, key, start pulse, done, result
//   busy                        : high while START or BUSY
//   timeout_err                 : sticky, set when the core never answers
// Handshake: a byte moves on a rising edge where valid && ready; valid is
// never withdrawn and the data never changes while valid && !ready.
module simon_byte_loader
  import simon_loader_pkg::*;
#(
  parameter int BLOCK_W        = DEF_BLOCK_W,
  parameter int KEY_W          = DEF_KEY_W,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         in_byte,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               keep_key,
  output logic [7:0]         out_byte,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] cipher_plaintext,
  output logic [KEY_W-1:0]   cipher_key,
  output logic               cipher_start,
  input  logic               cipher_done,
  input  logic [BLOCK_W-1:0] cipher_ciphertext,
  output logic               busy,
  output logic               timeout_err
);

  localparam int KEY_BYTES = KEY_W / 8;
  localparam int BLK_BYTES = BLOCK_W / 8;
  localparam int CNT_W     = cnt_w((KEY_BYTES > BLK_BYTES) ? KEY_BYTES : BLK_BYTES);
  localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY_BYTES - 1);
  localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(BLK_BYTES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic [BLOCK_W-1:0] pt_q, pt_d;
  logic [BLOCK_W-1:0] sh_q, sh_d;
  logic               terr_q, terr_d;
  logic               wd_clr, wd_en, wd_hit;
  logic               in_fire;

  simon_loader_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (wd_clr),
    .en_i  (wd_en),
    .hit_o (wd_hit)
  );

  assign in_ready         = (state_q == LOAD_KEY) || (state_q == LOAD_PT);
  assign in_fire          = in_valid && in_ready;
  assign out_valid        = (state_q == DRAIN);
  assign out_byte         = sh_q[7:0];
  assign cipher_start     = (state_q == START);
  assign busy             = (state_q == START) || (state_q == BUSY);
  assign cipher_key       = key_q;
  assign cipher_plaintext = pt_q;
  assign timeout_err      = terr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD_KEY;
      cnt_q   <= '0;
      key_q   <= '0;
      pt_q    <= '0;
      sh_q    <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      pt_q    <= pt_d;
      sh_q    <= sh_d;
      terr_q  <= terr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    pt_d    = pt_q;
    sh_d    = sh_q;
    terr_d  = terr_q;
    wd_clr  = 1'b1;
    wd_en   = 1'b0;

    // Any accepted byte acknowledges a previous timeout.
    if (in_fire) terr_d = 1'b0;

    case (state_q)
      LOAD_KEY: begin
        if (in_fire) begin
          key_d[{cnt_q, 3'b000} +: 8] = in_byte;
          if (cnt_q == KEY_LAST) begin
            cnt_d   = '0;
            state_d = LOAD_PT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      LOAD_PT: begin
        if (in_fire) begin
          pt_d[{cnt_q, 3'b000} +: 8] = in_byte;
          if (cnt_q == BLK_LAST) begin
            cnt_d   = '0;
            state_d = START;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      START: begin
        state_d = BUSY;
      end
      BUSY: begin
        wd_clr = 1'b0;
        if (cipher_done) begin
          sh_d    = cipher_ciphertext;
          state_d = DRAIN;
        end else begin
          wd_en = 1'b1;
          if (wd_hit) begin
            terr_d  = 1'b1;
            state_d = LOAD_KEY;
          end
        end
      end
      DRAIN: begin
        if (out_ready) begin
          sh_d = sh_q >> 8;
          if (cnt_q == BLK_LAST) begin
            cnt_d   = '0;
            state_d = keep_key ? LOAD_PT : LOAD_KEY;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = LOAD_KEY;
      end
    endcase
  end

endmodule

// File: tb/tb_simon_byte_loader.sv
module tb_simon_byte_loader;

  localparam int BW = 32;
  localparam int KW = 64;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    in_byte;
  logic          in_valid;
  logic          in_ready;
  logic          keep_key;
  logic [7:0]    out_byte;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] cipher_plaintext;
  logic [KW-1:0] cipher_key;
  logic          cipher_start;
  logic          cipher_done;
  logic [BW-1:0] cipher_ciphertext;
  logic          busy;
  logic          timeout_err;

  simon_byte_loader #(
    .BLOCK_W(BW),
    .KEY_W(KW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_byte(in_byte),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .keep_key(keep_key),
    .out_byte(out_byte),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .cipher_plaintext(cipher_plaintext),
    .cipher_key(cipher_key),
    .cipher_start(cipher_start),
    .cipher_done(cipher_done),
    .cipher_ciphertext(cipher_ciphertext),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state (transaction level).
  logic [7:0]  exp_q[$];
  logic [63:0] key_m;
  logic        need_key;
  logic        terr_m;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    need_key = 1'b1;
    terr_m   = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_byte"}, out_byte, 0);
    check({tag, "_start"}, cipher_start, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_terr"}, timeout_err, 0);
    check({tag, "_key"}, cipher_key, 0);
    check({tag, "_pt"}, cipher_plaintext, 0);
  endtask

  // ---------------- drivers ----------------
  // Bytes go out back-to-back; in_valid stays high on return.
  task automatic send_bytes(input logic [7:0] b[8], input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("in_ready_load", in_ready, 1);
      check("terr_load", timeout_err, terr_m);
      in_valid = 1'b1;
      in_byte  = b[i];
      if (i == 0) terr_m = 1'b0;
    end
  endtask

  // Loads (key if needed) + plaintext, checks the start pulse; returns at
  // the negedge inside BUSY cycle 1.
  task automatic load_and_start(input logic [7:0] kb[8], input logic [7:0] pb[8]);
    logic [63:0] kv;
    logic [63:0] pv;
    kv = 0;
    pv = 0;
    for (int k = 7; k >= 0; k--) kv = kv * 256 + 64'(kb[k]);
    for (int k = 3; k >= 0; k--) pv = pv * 256 + 64'(pb[k]);
    if (need_key) begin
      send_bytes(kb, 8);
      key_m = kv;
    end
    send_bytes(pb, 4);
    @(negedge clk);
    in_valid = 1'b0;
    check("start_pulse", cipher_start, 1);
    check("busy_start", busy, 1);
    check("in_ready_start", in_ready, 0);
    check("cipher_key", cipher_key, key_m);
    check("cipher_pt", cipher_plaintext, pv);
    @(negedge clk);
    check("start_once", cipher_start, 0);
    check("busy_wait", busy, 1);
  endtask

  // Core stub answers in BUSY cycle 'delay', then the output stream is drained.
  // rmode: 0 ready always, 1 alternate, 2 random. kmode: 0/1 forced, 2 random.
  task automatic finish_block(input int delay, input logic [31:0] ct, input int rmode, input int kmode);
    int budget;
    for (int i = 1; i < delay; i++) begin
      check("no_early_out", out_valid, 0);
      @(negedge clk);
    end
    cipher_done       = 1'b1;
    cipher_ciphertext = ct;
    for (int k = 0; k < 4; k++) exp_q.push_back(8'((ct / (32'd1 << (8 * k))) % 256));
    @(negedge clk);
    cipher_done       = 1'b0;
    cipher_ciphertext = $urandom;
    budget = 0;
    while (exp_q.size() > 0 && budget < 60) begin
      budget++;
      check("out_valid", out_valid, 1);
      check("out_byte", out_byte, exp_q[0]);
      check("in_ready_drain", in_ready, 0);
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = (budget % 2 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      keep_key = (kmode == 2) ? 1'($urandom_range(0, 1)) : 1'(kmode);
      in_valid = (exp_q.size() > 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      in_byte  = 8'($urandom);
      if (out_ready) begin
        if (exp_q.size() == 1) need_key = !keep_key;
        void'(exp_q.pop_front());
      end
      @(negedge clk);
    end
    if (exp_q.size() > 0) begin
      check("drain_budget", 64'(exp_q.size()), 0);
      exp_q.delete();
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    keep_key  = 1'b0;
    check("out_valid_drop", out_valid, 0);
    check("in_ready_after", in_ready, 1);
  endtask

  task automatic rand_bytes(output logic [7:0] b[8]);
    for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] kb[8];
  logic [7:0] pb[8];

  initial begin
    rst = 1'b1; in_byte = 0; in_valid = 0; keep_key = 0; out_ready = 0;
    cipher_done = 0; cipher_ciphertext = 0;
    key_m = 0; need_key = 1; terr_m = 0;
    do_reset();
    check_reset_outputs("reset");

    // Directed block: key 00..07, plaintext 10..13, core answers DEADBEEF.
    for (int i = 0; i < 8; i++) kb[i] = 8'(i);
    for (int i = 0; i < 8; i++) pb[i] = 8'(16 + i);
    load_and_start(kb, pb);
    check("key_literal", cipher_key, 64'h0706050403020100);
    finish_block(4, 32'hDEADBEEF, 0, 0);

    // Backpressure on alternate cycles, keep the key.
    rand_bytes(pb);
    load_and_start(kb, pb);
    finish_block(1, 32'h01234567, 1, 1);

    // Key is reused: only plaintext bytes are sent.
    rand_bytes(pb);
    load_and_start(kb, pb);
    check("kept_key", cipher_key, 64'h0706050403020100);
    finish_block(3, 32'hA5C3F00F, 2, 0);

    // Randomized blocks.
    for (int n = 0; n < 10; n++) begin
      rand_bytes(kb);
      rand_bytes(pb);
      load_and_start(kb, pb);
      finish_block($urandom_range(1, 10), $urandom, $urandom_range(0, 2), 2);
    end

    // Watchdog: core never answers.
    rand_bytes(kb);
    rand_bytes(pb);
    load_and_start(kb, pb);
    for (int i = 1; i <= TO; i++) begin
      check("wd_busy", busy, 1);
      check("wd_terr_low", timeout_err, 0);
      check("wd_no_out", out_valid, 0);
      @(negedge clk);
    end
    check("wd_terr_set", timeout_err, 1);
    check("wd_busy_drop", busy, 0);
    check("wd_in_ready", in_ready, 1);
    check("wd_no_out_after", out_valid, 0);
    terr_m   = 1'b1;
    need_key = 1'b1;
    @(negedge clk);
    check("wd_terr_sticky", timeout_err, 1);
    rand_bytes(kb);
    rand_bytes(pb);
    load_and_start(kb, pb);
    finish_block(2, $urandom, 0, 0);

    // Reset in the middle of BUSY, then a late done.
    rand_bytes(kb);
    rand_bytes(pb);
    load_and_start(kb, pb);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    need_key = 1'b1;
    terr_m   = 1'b0;
    check_reset_outputs("rst_busy");
    cipher_done       = 1'b1;
    cipher_ciphertext = $urandom;
    @(negedge clk);
    cipher_done = 1'b0;
    check_reset_outputs("late_done");
    @(negedge clk);
    check("late_done_no_out", out_valid, 0);

    // Fresh load after reset.
    rand_bytes(kb);
    rand_bytes(pb);
    load_and_start(kb, pb);
    finish_block(5, $urandom, 2, 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Hard bound on simulated time.
  initial begin
    #200000;
    $display("FAIL sim_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

endmodule
